// File: rtl/button_event_pkg.sv
// Shared types and sizing helper for the button event controller.
// BUTTON_EVENT_REPEAT_EN adds REPEAT events and sizes the hold counter for them.
package button_event_pkg;

   typedef enum logic [2:0] {
      PRESS         = 3'd0,
      RELEASE_SHORT = 3'd1,
      LONG_PRESS    = 3'd2,
      REPEAT        = 3'd3,
      RELEASE_LONG  = 3'd4
   } event_code_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } channel_state_e;

`ifdef BUTTON_EVENT_REPEAT_EN
   function automatic int counter_width(input int long_cycles, input int repeat_cycles);
      int span;
      span = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
      return ($clog2(span) > 1) ? $clog2(span) : 1;
   endfunction
`else
   function automatic int counter_width(input int long_cycles);
      return ($clog2(long_cycles) > 1) ? $clog2(long_cycles) : 1;
   endfunction
`endif

endpackage

// File: rtl/button_event_channel.sv
// One input channel: edge detect, hold-time FSM, one-deep pending slot and sticky drop flag.
// BUTTON_EVENT_REPEAT_EN enables REPEAT generation while the button stays in LONG.
module button_event_channel
   import button_event_pkg::*;
#(
   parameter int Long_Press_Cycles = 35_000_000
`ifdef BUTTON_EVENT_REPEAT_EN
   , parameter int Repeat_Cycles = 7_000_000
`endif
) (
   input  logic       clk,
   input  logic       async_rst_n,
   input  logic       clk_en,
   input  logic       level,
   input  logic       grant,
   input  logic       overflow_clear,
   output logic       pending,
   output logic [2:0] pending_code,
   output logic       overflow,
   output logic [1:0] state
);

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam int Count_Width = counter_width(Long_Press_Cycles, Repeat_Cycles);
   localparam logic [Count_Width-1:0] Repeat_Last = Count_Width'(Repeat_Cycles - 1);
`else
   localparam int Count_Width = counter_width(Long_Press_Cycles);
`endif
   localparam logic [Count_Width-1:0] Long_Last = Count_Width'(Long_Press_Cycles - 1);

   logic                   level_prev;
   logic                   rise;
   logic                   fall;
   channel_state_e         state_q;
   channel_state_e         state_d;
   logic [Count_Width-1:0] count_q;
   logic [Count_Width-1:0] count_d;
   logic                   raise;
   event_code_e            raise_code;
   logic                   full_q;
   event_code_e            code_q;
   logic                   overflow_q;
   logic                   store;
   logic                   drop;

   assign rise = clk_en & level & ~level_prev;
   assign fall = clk_en & ~level & level_prev;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         level_prev <= 1'b0;
         state_q    <= IDLE;
         count_q    <= '0;
      end else begin
         if (clk_en) begin
            level_prev <= level;
         end
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // A fall is tested before the terminal count so a release never also reports a long press.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      raise      = 1'b0;
      raise_code = PRESS;
      if (clk_en) begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d    = HELD;
                  count_d    = '0;
                  raise      = 1'b1;
                  raise_code = PRESS;
               end
            end
            HELD: begin
               if (fall) begin
                  state_d    = IDLE;
                  count_d    = '0;
                  raise      = 1'b1;
                  raise_code = RELEASE_SHORT;
               end else if (count_q == Long_Last) begin
                  state_d    = LONG;
                  count_d    = '0;
                  raise      = 1'b1;
                  raise_code = LONG_PRESS;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
            LONG: begin
               if (fall) begin
                  state_d    = IDLE;
                  count_d    = '0;
                  raise      = 1'b1;
                  raise_code = RELEASE_LONG;
`ifdef BUTTON_EVENT_REPEAT_EN
               end else if (count_q == Repeat_Last) begin
                  count_d    = '0;
                  raise      = 1'b1;
                  raise_code = REPEAT;
               end else begin
                  count_d = count_q + 1'b1;
`endif
               end
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // A slot being granted this cycle is free for the newly raised event.
   assign store = raise & (~full_q | grant);
   assign drop  = raise & full_q & ~grant;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         full_q     <= 1'b0;
         code_q     <= PRESS;
         overflow_q <= 1'b0;
      end else begin
         if (store) begin
            full_q <= 1'b1;
            code_q <= raise_code;
         end else if (grant) begin
            full_q <= 1'b0;
         end
         overflow_q <= (overflow_q & ~overflow_clear) | drop;
      end
   end

   assign pending      = full_q;
   assign pending_code = code_q;
   assign overflow     = overflow_q;
   assign state        = state_q;

endmodule

// File: rtl/button_event_controller.sv
// Per-channel hold sequencers sharing one registered event port through a round-robin arbiter.
// BUTTON_EVENT_REPEAT_EN enables REPEAT events; channel_state exposes each channel FSM for debug.
module button_event_controller
   import button_event_pkg::*;
#(
   parameter int Channel_Count     = 4,
   parameter int Long_Press_Cycles = 35_000_000,
   parameter int Repeat_Cycles     = 7_000_000,
   localparam int Channel_Width    = ($clog2(Channel_Count) > 1) ? $clog2(Channel_Count) : 1
) (
   input  logic                       clk,
   input  logic                       async_rst_n,
   input  logic                       clk_en,
   input  logic [Channel_Count-1:0]   levels_in,
   output logic                       event_valid,
   input  logic                       event_ready,
   output logic [Channel_Width-1:0]   event_channel,
   output logic [2:0]                 event_code,
   output logic [Channel_Count-1:0]   overflow,
   input  logic [Channel_Count-1:0]   overflow_clear,
   output logic [2*Channel_Count-1:0] channel_state
);

   localparam int Sum_Width = Channel_Width + 1;

   if (Channel_Count < 2) begin : g_bad_channel_count
      $error("Channel_Count must be at least 2");
   end
   if (Long_Press_Cycles < 2) begin : g_bad_long_press
      $error("Long_Press_Cycles must be at least 2");
   end
   if (Repeat_Cycles < 2) begin : g_bad_repeat
      $error("Repeat_Cycles must be at least 2");
   end

   logic [Channel_Count-1:0] pending;
   logic [2:0]               slot_code [Channel_Count];
   logic [Channel_Count-1:0] grant;
   logic [Channel_Width-1:0] rr_ptr;
   logic [Channel_Width-1:0] pick;
   logic [Channel_Width-1:0] next_rr;
   logic [Sum_Width-1:0]     cand;
   logic                     found;
   logic                     load;

   for (genvar g = 0; g < Channel_Count; g++) begin : g_channel
      button_event_channel #(
         .Long_Press_Cycles(Long_Press_Cycles)
`ifdef BUTTON_EVENT_REPEAT_EN
         , .Repeat_Cycles(Repeat_Cycles)
`endif
      ) u_channel (
         .clk           (clk),
         .async_rst_n   (async_rst_n),
         .clk_en        (clk_en),
         .level         (levels_in[g]),
         .grant         (grant[g]),
         .overflow_clear(overflow_clear[g]),
         .pending       (pending[g]),
         .pending_code  (slot_code[g]),
         .overflow      (overflow[g]),
         .state         (channel_state[2*g +: 2])
      );
   end

   // First full slot at or after rr_ptr, wrapping around the channel count.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < Channel_Count; i++) begin
         cand = {1'b0, rr_ptr} + Sum_Width'(i);
         if (cand >= Sum_Width'(Channel_Count)) begin
            cand = cand - Sum_Width'(Channel_Count);
         end
         if (!found && pending[cand[Channel_Width-1:0]]) begin
            found = 1'b1;
            pick  = cand[Channel_Width-1:0];
         end
      end
   end

   // Handshake: event_valid/event_channel/event_code hold until a cycle with
   // event_valid && event_ready; the next event loads in that same cycle, so
   // transfers can occur every cycle. Arbitration runs regardless of clk_en.
   assign load    = ~event_valid | event_ready;
   assign next_rr = (pick == Channel_Width'(Channel_Count - 1)) ? '0 : pick + 1'b1;

   always_comb begin
      grant = '0;
      if (load && found) begin
         grant[pick] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         event_valid   <= 1'b0;
         event_channel <= '0;
         event_code    <= 3'd0;
         rr_ptr        <= '0;
      end else if (load) begin
         event_valid <= found;
         if (found) begin
            event_channel <= pick;
            event_code    <= slot_code[pick];
            rr_ptr        <= next_rr;
         end
      end
   end

endmodule

// File: tb/tb_button_event_controller.sv
// Directed bench for button_event_controller with a hold-time based reference model.
// Honours BUTTON_EVENT_REPEAT_EN when deciding whether REPEAT events are expected.
module tb_button_event_controller;

   localparam int N = 4;
   localparam int L = 8;
   localparam int R = 4;
   localparam logic [2:0] C_PRESS = 3'd0;
   localparam logic [2:0] C_RS    = 3'd1;
   localparam logic [2:0] C_LONG  = 3'd2;
   localparam logic [2:0] C_REP   = 3'd3;
   localparam logic [2:0] C_RL    = 3'd4;

   logic           clk = 1'b0;
   logic           async_rst_n = 1'b1;
   logic           clk_en = 1'b0;
   logic           event_ready = 1'b0;
   logic [N-1:0]   levels_in = '0;
   logic [N-1:0]   overflow_clear = '0;
   logic           event_valid;
   logic [1:0]     event_channel;
   logic [2:0]     event_code;
   logic [N-1:0]   overflow;
   logic [2*N-1:0] channel_state;

   int total = 0;
   int bad = 0;
   logic [4:0] exp_q[$];
   logic [4:0] got_q[$];

   // model state
   logic       m_prev [N];
   int         m_hold [N];
   logic       m_full [N];
   logic [2:0] m_slot [N];
   logic [N-1:0] m_ovf;
   logic       m_valid;
   int         m_ch;
   logic [2:0] m_code;
   int         m_rr;
   logic       m_raise [N];
   logic [2:0] m_rcode [N];
   logic       m_found;
   int         m_g;
   int         m_c;

   button_event_controller #(
      .Channel_Count    (N),
      .Long_Press_Cycles(L),
      .Repeat_Cycles    (R)
   ) dut (
      .clk           (clk),
      .async_rst_n   (async_rst_n),
      .clk_en        (clk_en),
      .levels_in     (levels_in),
      .event_valid   (event_valid),
      .event_ready   (event_ready),
      .event_channel (event_channel),
      .event_code    (event_code),
      .overflow      (overflow),
      .overflow_clear(overflow_clear),
      .channel_state (channel_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] ev(input int ch, input logic [2:0] code);
      return {2'(ch), code};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_log(input string name);
      check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check(name, 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Reference model: events follow from how long each level has been held.
   initial begin
      forever begin
         @(posedge clk or negedge async_rst_n);
         if (!async_rst_n) begin
            for (int c = 0; c < N; c++) begin
               m_prev[c] = 1'b0;
               m_hold[c] = 0;
               m_full[c] = 1'b0;
               m_slot[c] = 3'd0;
            end
            m_ovf   = '0;
            m_valid = 1'b0;
            m_ch    = 0;
            m_code  = 3'd0;
            m_rr    = 0;
         end else begin
            for (int c = 0; c < N; c++) begin
               m_raise[c] = 1'b0;
               m_rcode[c] = 3'd0;
               if (clk_en) begin
                  if (levels_in[c] && !m_prev[c]) begin
                     m_raise[c] = 1'b1;
                     m_rcode[c] = C_PRESS;
                     m_hold[c]  = 0;
                  end else if (!levels_in[c] && m_prev[c]) begin
                     m_raise[c] = 1'b1;
                     m_rcode[c] = (m_hold[c] + 1 > L) ? C_RL : C_RS;
                  end else if (levels_in[c]) begin
                     m_hold[c] = m_hold[c] + 1;
                     if (m_hold[c] == L) begin
                        m_raise[c] = 1'b1;
                        m_rcode[c] = C_LONG;
                     end
`ifdef BUTTON_EVENT_REPEAT_EN
                     if (m_hold[c] > L && (m_hold[c] - L) % R == 0) begin
                        m_raise[c] = 1'b1;
                        m_rcode[c] = C_REP;
                     end
`endif
                  end
                  m_prev[c] = levels_in[c];
               end
            end
            if (!m_valid || event_ready) begin
               m_found = 1'b0;
               m_g = 0;
               for (int k = 0; k < N; k++) begin
                  m_c = (m_rr + k) % N;
                  if (!m_found && m_full[m_c]) begin
                     m_found = 1'b1;
                     m_g = m_c;
                  end
               end
               m_valid = m_found;
               if (m_found) begin
                  m_ch = m_g;
                  m_code = m_slot[m_g];
                  m_full[m_g] = 1'b0;
                  m_rr = (m_g + 1) % N;
               end
            end
            m_ovf = m_ovf & ~overflow_clear;
            for (int c = 0; c < N; c++) begin
               if (m_raise[c]) begin
                  if (!m_full[c]) begin
                     m_full[c] = 1'b1;
                     m_slot[c] = m_rcode[c];
                  end else begin
                     m_ovf[c] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // scoreboard: every cycle against the model, plus a log of accepted events
   always @(negedge clk) begin
      check("valid", 32'(event_valid), 32'(m_valid));
      if (m_valid) begin
         check("channel", 32'(event_channel), 32'(m_ch));
         check("code", 32'(event_code), 32'(m_code));
      end
      check("overflow", 32'(overflow), 32'(m_ovf));
   end

   always @(posedge clk) begin
      if (async_rst_n && event_valid && event_ready) begin
         got_q.push_back({event_channel, event_code});
      end
   end

   // driver
   initial begin
      #1 async_rst_n = 1'b0;
      step(3);
      check("rst_valid", 32'(event_valid), 32'd0);
      check("rst_channel", 32'(event_channel), 32'd0);
      check("rst_code", 32'(event_code), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      async_rst_n = 1'b1;
      clk_en      = 1'b1;
      event_ready = 1'b1;
      step(2);

      // all channels rise together, then fall together
      levels_in = 4'b1111;
      step(6);
      levels_in = 4'b0000;
      step(8);
      for (int c = 0; c < N; c++) exp_q.push_back(ev(c, C_PRESS));
      for (int c = 0; c < N; c++) exp_q.push_back(ev(c, C_RS));
      check_log("all_channels");

      // short press on ch0 with latency pinned
      levels_in = 4'b0001;
      step(1);
      check("lat_slot_only", 32'(event_valid), 32'd0);
      step(1);
      check("lat_valid", 32'(event_valid), 32'd1);
      check("lat_channel", 32'(event_channel), 32'd0);
      check("lat_code", 32'(event_code), 32'(C_PRESS));
      step(1);
      levels_in = 4'b0000;
      step(5);
      exp_q.push_back(ev(0, C_PRESS));
      exp_q.push_back(ev(0, C_RS));
      check_log("short_ch0");

      // long hold on ch1
      levels_in = 4'b0010;
      step(9);
      check("long_not_yet", 32'(event_valid), 32'd0);
      step(1);
      check("long_valid", 32'(event_valid), 32'd1);
      check("long_code", 32'(event_code), 32'(C_LONG));
      check("long_channel", 32'(event_channel), 32'd1);
      step(10);
      levels_in = 4'b0000;
      step(6);
      exp_q.push_back(ev(1, C_PRESS));
      exp_q.push_back(ev(1, C_LONG));
`ifdef BUTTON_EVENT_REPEAT_EN
      exp_q.push_back(ev(1, C_REP));
      exp_q.push_back(ev(1, C_REP));
`endif
      exp_q.push_back(ev(1, C_RL));
      check_log("long_ch1");

      // backpressure with ch2 toggling: second PRESS is dropped
      event_ready = 1'b0;
      levels_in = 4'b0100;
      step(3);
      check("bp_hold_code", 32'(event_code), 32'(C_PRESS));
      check("bp_hold_channel", 32'(event_channel), 32'd2);
      levels_in = 4'b0000;
      step(3);
      check("bp_still_valid", 32'(event_valid), 32'd1);
      levels_in = 4'b0100;
      step(3);
      check("bp_overflow", 32'(overflow), 32'h4);
      check("bp_still_press", 32'(event_code), 32'(C_PRESS));
      event_ready = 1'b1;
      step(3);
      levels_in = 4'b0000;
      step(4);
      exp_q.push_back(ev(2, C_PRESS));
      exp_q.push_back(ev(2, C_RS));
      exp_q.push_back(ev(2, C_RS));
      check_log("backpressure_ch2");
      overflow_clear = 4'b0100;
      step(1);
      overflow_clear = 4'b0000;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // clk_en low while ch3 is held: drain continues, hold time pauses
      levels_in = 4'b1000;
      step(1);
      clk_en = 1'b0;
      step(10);
      check("en_low_drained", 32'(got_q.size()), 32'd1);
      check("en_low_event", 32'(got_q[0]), 32'(ev(3, C_PRESS)));
      clk_en = 1'b1;
      step(10);
      levels_in = 4'b0000;
      step(5);
      exp_q.push_back(ev(3, C_PRESS));
      exp_q.push_back(ev(3, C_LONG));
      exp_q.push_back(ev(3, C_RL));
      check_log("clk_en_ch3");

      // reset in the middle of a long hold with events pending
      event_ready = 1'b0;
      levels_in = 4'b0110;
      step(2);
      levels_in = 4'b0010;
      step(8);
      check("pre_rst_valid", 32'(event_valid), 32'd1);
      check("pre_rst_channel", 32'(event_channel), 32'd1);
      check("pre_rst_overflow", 32'(overflow), 32'h4);
      #2 async_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(event_valid), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      got_q.delete();
      async_rst_n = 1'b1;
      event_ready = 1'b1;
      step(3);
      levels_in = 4'b0000;
      step(5);
      exp_q.push_back(ev(1, C_PRESS));
      exp_q.push_back(ev(1, C_RS));
      check_log("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_event_controller.md
Name: button_event_controller

Overview:
- Sits downstream of a bank of `level_debouncer` instances and turns their stable levels into discrete user-input events.
- Events: press, short release, long press, auto-repeat and long release.
- Each channel owns a hold-time sequencer. A round-robin arbiter shares one valid/ready event port among all channels.
- Feeds the control FSM or a CSR event FIFO.

Parameters:
- Channel_Count, 4: number of debounced inputs; minimum 2.
- Long_Press_Cycles, 35_000_000: clk_en cycles a level must stay high before LONG_PRESS (1 s @ 35 MHz); minimum 2.
- Repeat_Cycles, 7_000_000: clk_en cycles between REPEAT events while held past long press; minimum 2.

Ports:
- clk, input, 1: system clock.
- async_rst_n, input, 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- clk_en, input, 1: global enable; timers and edge detection advance only when high.
- levels_in, input, Channel_Count: debounced levels, already synchronous to clk.
- event_valid, output, 1: event available.
- event_ready, input, 1: consumer accepts the event.
- event_channel, output, Channel_Width: source channel, where Channel_Width = max(1, $clog2(Channel_Count)).
- event_code, output, 3: event type.
- overflow, output, Channel_Count: sticky per-channel drop flag.
- overflow_clear, input, Channel_Count: write-1-to-clear for overflow.

Behaviour:
- Reset (async, all state): level_prev=0, channel FSM=IDLE, counters=0, pending=0, overflow=0, event_valid=0, event_channel=0, event_code=0, rr pointer=0. A level already high on the first clk_en after reset yields PRESS.
- Event codes: PRESS=0, RELEASE_SHORT=1, LONG_PRESS=2, REPEAT=3, RELEASE_LONG=4. Codes 5–7 are never emitted.
- Per-channel FSM, evaluated only on clk_en:
  - IDLE: rise → HELD, counter=0, raise PRESS.
  - HELD: fall → IDLE, raise RELEASE_SHORT. Counter==Long_Press_Cycles-1 → LONG, counter=0, raise LONG_PRESS. Otherwise counter+1.
  - LONG: fall → IDLE, raise RELEASE_LONG. Counter==Repeat_Cycles-1 → counter=0, raise REPEAT. Otherwise counter+1.
  - Fall takes priority over a terminal count in the same cycle.
- Counter width: $clog2(max(Long_Press_Cycles, Repeat_Cycles)); the counter never wraps past its limit.
- Pending slot: one entry per channel (code plus full bit).
  - Raising into an empty slot, or into a slot being granted in the same cycle, stores the new event.
  - Raising into a full slot that is not granted that cycle drops the new event, keeps the old one and sets overflow[ch].
  - overflow_clear and a new overflow in the same cycle leave the bit set.
- Arbiter: round-robin starting at rr pointer over full pending slots.
  - The output register loads when event_valid=0, or when event_valid && event_ready.
  - Loading clears the granted slot and sets rr pointer = granted+1, modulo Channel_Count.
  - Arbitration ignores clk_en, so the output drains while the enable is low.
- Handshake: event_valid, event_channel and event_code are registered and stay stable until event_valid && event_ready. A back-to-back handshake every cycle is supported.
- Latency: level change seen on clk_en cycle N → slot full at N+1 → event_valid at N+2 if the output is free.
- Reset mid-operation: all pending and output events are discarded; no partial event is emitted.

Optional Feature:
- Macro BUTTON_EVENT_REPEAT_EN.
- Defined: REPEAT events are produced as described.
- Undefined:
  - LONG holds silently until the fall.
  - The counter stops at LONG entry.
  - Repeat_Cycles is unused, and the counter width depends on Long_Press_Cycles only.
  - Code 3 is never emitted.

Decomposition:
- Package button_event_pkg holds:
  - the event_code_e enum (3-bit);
  - the channel_state_e enum (IDLE, HELD, LONG; 2-bit);
  - a function returning the counter width.
- Sub-module button_event_channel contains the edge detect, FSM, counter, pending slot and overflow bit. It is instantiated Channel_Count times via generate.
- The top level holds the arbiter and output register.

Test Plan (Long_Press_Cycles=8, Repeat_Cycles=4, Channel_Count=4, clk_en=1, event_ready=1 unless stated):
- ch0 high for 3 cycles, then low → PRESS(ch0) two cycles after the rise, then RELEASE_SHORT(ch0); no LONG_PRESS.
- ch1 high for 20 cycles → PRESS, LONG_PRESS 8 cycles after the rise, REPEAT every 4 cycles (2×), then RELEASE_LONG. With the macro undefined: PRESS, LONG_PRESS, RELEASE_LONG only.
- ch0–ch3 all rise in the same cycle → four consecutive PRESS events in order ch0, ch1, ch2, ch3. Then a simultaneous fall, rr pointer=0 → RELEASE_SHORT in order ch0, ch1, ch2, ch3.
- event_ready=0 while ch2 toggles high/low/high → the first PRESS is held stable on the output. RELEASE_SHORT sits in the slot, the second PRESS is dropped and overflow[2]=1. After ready, RELEASE_SHORT follows. overflow_clear[2] → overflow[2]=0.
- clk_en low for 10 cycles while ch3 is held high → no LONG_PRESS. The counter resumes when clk_en returns, and the pending event still drains during the clk_en=0 window.
- async_rst_n asserted while ch1 is in LONG with an event pending → event_valid=0 and overflow=0 immediately. After release with ch1 still high → a fresh PRESS(ch1).
